pwm_gen_multi: RTL and testbench
================================

# pwm_gen_multi

Multi-channel PWM generator: the parametrised successor to the team's single-channel 10-step PWM block. It drives CHANNELS PWM outputs from one shared period counter. Each channel has its own duty register, adjusted by debounced increase/decrease push-button inputs. Duty changes apply glitch-free at period boundaries, and a run-time mode selects edge-aligned or center-aligned output. The block sits behind the top-level wrapper, with buttons on dedicated inputs and PWM lines on dedicated outputs.

## Interface
- CHANNELS, 2: number of independent PWM channels.
- PERIOD, 10: counter steps per edge-aligned period. Must be 2..(2**CNT_W − 1).
- CNT_W, 4: counter and duty width. Must satisfy 2**CNT_W > PERIOD.
- STEP, 1: duty change per press, ≥1.
- DUTY_RST, 5: duty value after reset, ≤ PERIOD.
- DEB_CYCLES, 4: consecutive stable cycles required by the debounce filter, ≥1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- inc_in  input  CHANNELS  per-channel increase-duty button. Asynchronous, level.
- dec_in  input  CHANNELS  per-channel decrease-duty button. Asynchronous, level.
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned. Sampled only at a period boundary.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_start  output  1  one-cycle pulse marking the first cycle of each period.
- duty_out  output  CHANNELS*CNT_W  active duty for each channel. Channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- **Input synchronisation:** every inc_in/dec_in bit passes through a 2-flop synchroniser. A per-bit debounce counter then updates the filtered level only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter.
- **Press event:** a rising edge of the filtered level produces a one-cycle pulse. Holding a button produces exactly one event; releasing produces none.
- **Shadow duty (per channel), updated the cycle after the event:**
  - inc only: shadow = min(shadow + STEP, PERIOD).
  - dec only: shadow = max(shadow − STEP, 0).
  - inc and dec in the same cycle: unchanged.
  - Arithmetic is done one bit wider than CNT_W, so no wrap-around can occur.
- **Active duty:** loads from shadow only at a period boundary. duty_out shows the active duty.
- **Edge-aligned mode:** the counter runs 0..PERIOD−1 and wraps to 0. The boundary is the wrap. Each pwm_out is the registered value of (cnt < active duty).
  - duty 0 gives constant low; duty PERIOD gives constant high.
- **Center-aligned mode:** the counter runs up 0..PERIOD−1, then down PERIOD−1..0. Each endpoint value is held for one cycle per direction, giving a period of 2*PERIOD cycles. The boundary is the transition from down-count cnt=0 to up-count cnt=0. pwm_out is the registered value of (cnt < active duty), so the high pulse is centred on the boundary.
- **Mode switching:** center_mode is sampled at each boundary. A mode change takes effect only from the new period, with the counter restarting at 0 counting up.

## Timing
- **Reset (asynchronous, immediate):**
  - pwm_out = 0 and period_start = 0.
  - Counter = 0, direction = up.
  - Shadow and active duty = DUTY_RST; duty_out = DUTY_RST.
  - Synchroniser, filtered levels and debounce counters = 0.
  - Mode register = 0 (edge-aligned).
- **After reset release:** the first clock edge with rst_n high evaluates cnt = 0. pwm_out and period_start reflect that count one cycle later, i.e. pwm_out has 1-cycle latency from the counter.
- **period_start:** asserted in the same cycle that pwm_out first reflects cnt = 0 of a new period.
- **Press latency:** 2 cycles (synchroniser) + DEB_CYCLES (debounce) + 1 cycle (event pulse) + 1 cycle (shadow update). The new duty reaches pwm_out in the first period starting after the shadow update.
- **Boundary collision:** a shadow update landing in the same cycle as the boundary load is not included in that load; it applies at the following boundary.
- **Mid-operation reset:** rst_n low at any point takes effect immediately. In-flight presses are discarded.

## Test plan
- **Default reset, edge mode, no presses:** on both channels, pwm_out is high 5 cycles then low 5, repeating. period_start pulses every 10 cycles, aligned with the rising edge of pwm_out. duty_out = {5, 5}.
- **Increase on one channel:** hold inc_in[0] for 20 cycles. duty_out channel 0 becomes 6, and from the next period channel 0 is high 6 / low 4. Channel 1 stays at 5/5. Exactly one increment occurs per hold.
- **Saturation:** 7 inc presses on channel 0 give duty 10 and constant-high output. Then 12 dec presses give duty 0 and constant-low output. Duty never wraps.
- **Debounce rejection and simultaneous presses:**
  - A 2-cycle glitch on inc_in[1] leaves duty unchanged.
  - inc_in[1] and dec_in[1] asserted together and held 20 cycles leave duty unchanged.
- **Center-aligned mode:** set center_mode = 1 with duty 5. After the next boundary, pwm_out is high 10 / low 10 contiguously and period_start pulses every 20 cycles. Returning center_mode to 0 restores the 10-cycle period only after the current period completes.
- **Mid-operation reset:** with duty 8 and pwm_out high, drop rst_n between clock edges. pwm_out goes to 0 immediately. After release, duty_out = 5 and the 5/5 pattern restarts from cnt = 0.

Source files
------------

// File: rtl/pwm_gen_multi_if.sv
// Button, mode and PWM signal bundle for pwm_gen_multi.
// The slave modport is the generator's view; the master modport is the wrapper or bench driving it.
interface pwm_gen_multi_if #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 4
);
   logic [CHANNELS-1:0]       inc_in;
   logic [CHANNELS-1:0]       dec_in;
   logic                      center_mode;
   logic [CHANNELS-1:0]       pwm_out;
   logic                      period_start;
   logic [CHANNELS*CNT_W-1:0] duty_out;

   modport master (
      output inc_in,
      output dec_in,
      output center_mode,
      input  pwm_out,
      input  period_start,
      input  duty_out
   );

   modport slave (
      input  inc_in,
      input  dec_in,
      input  center_mode,
      output pwm_out,
      output period_start,
      output duty_out
   );
endinterface

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel debounced duty buttons,
// glitch-free duty reload at period boundaries, edge- or center-aligned output.
module pwm_gen_multi #(
   parameter int CHANNELS   = 2,
   parameter int PERIOD     = 10,
   parameter int CNT_W      = 4,
   parameter int STEP       = 1,
   parameter int DUTY_RST   = 5,
   parameter int DEB_CYCLES = 4
) (
   input logic               clk,
   input logic               rst_n,
   pwm_gen_multi_if.slave    bus
);
   localparam int BTN   = 2 * CHANNELS;
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] DUTY_RST_C = CNT_W'(DUTY_RST);
   localparam logic [CNT_W:0]   PERIOD_W  = (CNT_W+1)'(PERIOD);
   localparam logic [CNT_W:0]   STEP_W    = (CNT_W+1)'(STEP);
   localparam logic [DEB_W-1:0] DEB_ZERO  = {DEB_W{1'b0}};
   localparam logic [DEB_W-1:0] DEB_ONE   = {{(DEB_W-1){1'b0}}, 1'b1};
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_UP   = 1'b0,
      ST_DOWN = 1'b1
   } dir_e;

   // Button bits are packed as {dec[CHANNELS-1:0], inc[CHANNELS-1:0]}.
   logic [BTN-1:0]                sync1_r;
   logic [BTN-1:0]                sync2_r;
   logic [BTN-1:0]                filt_r;
   logic [BTN-1:0]                filt_d_r;
   logic [BTN-1:0]                ev_r;
   logic [BTN-1:0][DEB_W-1:0]     deb_cnt_r;

   logic [CHANNELS-1:0][CNT_W-1:0] shadow_r;
   logic [CHANNELS-1:0][CNT_W-1:0] shadow_nxt_s;
   logic [CHANNELS-1:0][CNT_W:0]   sum_s;
   logic [CHANNELS-1:0][CNT_W:0]   diff_s;
   logic [CHANNELS-1:0][CNT_W-1:0] active_r;

   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;
   dir_e                dir_r;
   dir_e                dir_nxt_s;
   logic                mode_r;
   logic                boundary_s;
   logic [CHANNELS-1:0] pwm_r;
   logic                period_start_r;

   // Two-flop synchroniser for the asynchronous button levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= {BTN{1'b0}};
         sync2_r <= {BTN{1'b0}};
      end else begin
         sync1_r <= {bus.dec_in, bus.inc_in};
         sync2_r <= sync1_r;
      end
   end

   // Debounce filter: a level change is accepted after DEB_CYCLES consecutive mismatching cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_r    <= {BTN{1'b0}};
         deb_cnt_r <= {BTN{DEB_ZERO}};
      end else begin
         for (int i = 0; i < BTN; i++) begin
            if (sync2_r[i] != filt_r[i]) begin
               if (deb_cnt_r[i] == DEB_LAST) begin
                  filt_r[i]    <= sync2_r[i];
                  deb_cnt_r[i] <= DEB_ZERO;
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
               end
            end else begin
               deb_cnt_r[i] <= DEB_ZERO;
            end
         end
      end
   end

   // Press events: one-cycle pulse on each rising edge of a filtered level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_d_r <= {BTN{1'b0}};
         ev_r     <= {BTN{1'b0}};
      end else begin
         filt_d_r <= filt_r;
         ev_r     <= filt_r & ~filt_d_r;
      end
   end

   // One-bit-wider step arithmetic so saturation is decided before any truncation.
   always_comb begin
      sum_s  = {CHANNELS{{(CNT_W+1){1'b0}}}};
      diff_s = {CHANNELS{{(CNT_W+1){1'b0}}}};
      for (int i = 0; i < CHANNELS; i++) begin
         sum_s[i]  = {1'b0, shadow_r[i]} + STEP_W;
         diff_s[i] = {1'b0, shadow_r[i]} - STEP_W;
      end
   end

   // Next shadow duty; simultaneous inc and dec cancel out.
   always_comb begin
      shadow_nxt_s = shadow_r;
      for (int i = 0; i < CHANNELS; i++) begin
         case ({ev_r[CHANNELS+i], ev_r[i]})
            2'b01:   shadow_nxt_s[i] = (sum_s[i] > PERIOD_W) ? PERIOD_C : sum_s[i][CNT_W-1:0];
            2'b10:   shadow_nxt_s[i] = ({1'b0, shadow_r[i]} < STEP_W) ? CNT_ZERO : diff_s[i][CNT_W-1:0];
            default: shadow_nxt_s[i] = shadow_r[i];
         endcase
      end
   end

   // Shadow duty register; the active copy only follows it at a period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_r <= {CHANNELS{DUTY_RST_C}};
         active_r <= {CHANNELS{DUTY_RST_C}};
      end else begin
         shadow_r <= shadow_nxt_s;
         if (boundary_s) begin
            active_r <= shadow_r;
         end
      end
   end

   // Counter direction state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_r <= ST_UP;
      end else begin
         dir_r <= dir_nxt_s;
      end
   end

   // Direction next-state: only center-aligned mode ever turns around at the top.
   always_comb begin
      dir_nxt_s = dir_r;
      case (dir_r)
         ST_UP: begin
            if (mode_r && (cnt_r == PERIOD_M1)) begin
               dir_nxt_s = ST_DOWN;
            end else begin
               dir_nxt_s = ST_UP;
            end
         end
         ST_DOWN: begin
            if (cnt_r == CNT_ZERO) begin
               dir_nxt_s = ST_UP;
            end else begin
               dir_nxt_s = ST_DOWN;
            end
         end
         default: dir_nxt_s = ST_UP;
      endcase
   end

   // Counter next value and boundary flag; both endpoints repeat once when turning around.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      boundary_s = 1'b0;
      case (dir_r)
         ST_UP: begin
            if (cnt_r == PERIOD_M1) begin
               if (mode_r) begin
                  cnt_nxt_s  = cnt_r;
                  boundary_s = 1'b0;
               end else begin
                  cnt_nxt_s  = CNT_ZERO;
                  boundary_s = 1'b1;
               end
            end else begin
               cnt_nxt_s  = cnt_r + CNT_ONE;
               boundary_s = 1'b0;
            end
         end
         ST_DOWN: begin
            if (cnt_r == CNT_ZERO) begin
               cnt_nxt_s  = CNT_ZERO;
               boundary_s = 1'b1;
            end else begin
               cnt_nxt_s  = cnt_r - CNT_ONE;
               boundary_s = 1'b0;
            end
         end
         default: begin
            cnt_nxt_s  = CNT_ZERO;
            boundary_s = 1'b1;
         end
      endcase
   end

   // Shared counter and the mode latched for the whole period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= CNT_ZERO;
         mode_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         if (boundary_s) begin
            mode_r <= bus.center_mode;
         end
      end
   end

   // Registered outputs, one cycle behind the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_r          <= {CHANNELS{1'b0}};
         period_start_r <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_r[i] <= (cnt_r < active_r[i]);
         end
         period_start_r <= (cnt_r == CNT_ZERO) && (dir_r == ST_UP);
      end
   end

   assign bus.pwm_out      = pwm_r;
   assign bus.period_start = period_start_r;
   assign bus.duty_out     = active_r;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Self-checking bench for pwm_gen_multi: directed scenarios plus random presses,
// compared against a saturating duty model and per-period waveform arithmetic.
module tb_pwm_gen_multi;
   localparam int CH = 2;
   localparam int P  = 10;
   localparam int W  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_gen_multi_if #(.CHANNELS(CH), .CNT_W(W)) bus ();

   pwm_gen_multi #(
      .CHANNELS(CH), .PERIOD(P), .CNT_W(W), .STEP(1), .DUTY_RST(5), .DEB_CYCLES(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int duty_m [CH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected pwm level at position k of a period, straight from the waveform definition.
   function automatic int exp_pwm(input int mode, input int k, input int duty);
      int c;
      if (mode == 0) c = k;
      else if (k < P) c = k;
      else c = 2 * P - 1 - k;
      return (c < duty) ? 1 : 0;
   endfunction

   task automatic check_duty();
      for (int c = 0; c < CH; c++)
         chk($sformatf("duty_ch%0d", c), 32'(bus.duty_out[c*W +: W]), 32'(duty_m[c]));
   endtask

   task automatic wait_ps();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.period_start === 1'b1) return;
      end
      total++;
      bad++;
      $error("FAIL ps_timeout observed=none expected=period_start within 60 cycles");
   endtask

   // Called on the sample where a period starts; ends on the sample where the next one starts.
   task automatic check_period(input int mode);
      int len;
      len = (mode != 0) ? 2 * P : P;
      for (int k = 0; k < len; k++) begin
         chk($sformatf("ps_m%0d_k%0d", mode, k), 32'(bus.period_start), (k == 0) ? 32'd1 : 32'd0);
         for (int c = 0; c < CH; c++)
            chk($sformatf("pwm_ch%0d_m%0d_k%0d", c, mode, k), 32'(bus.pwm_out[c]),
                32'(exp_pwm(mode, k, duty_m[c])));
         @(negedge clk);
      end
      chk($sformatf("ps_next_m%0d", mode), 32'(bus.period_start), 32'd1);
   endtask

   // kind: 0 inc, 1 dec, 2 inc+dec together, 3 short inc glitch
   task automatic do_press(input int ch, input int kind);
      int hold;
      hold = (kind == 3) ? 2 : 20;
      @(negedge clk);
      if (kind == 0 || kind == 2 || kind == 3) bus.inc_in[ch] = 1'b1;
      if (kind == 1 || kind == 2) bus.dec_in[ch] = 1'b1;
      repeat (hold) @(negedge clk);
      bus.inc_in = '0;
      bus.dec_in = '0;
      repeat (12) @(negedge clk);
      if (kind == 0) duty_m[ch] = (duty_m[ch] + 1 > P) ? P : duty_m[ch] + 1;
      else if (kind == 1) duty_m[ch] = (duty_m[ch] - 1 < 0) ? 0 : duty_m[ch] - 1;
   endtask

   initial begin
      bus.inc_in      = '0;
      bus.dec_in      = '0;
      bus.center_mode = 1'b0;
      duty_m[0] = 5;
      duty_m[1] = 5;

      // Reset state
      #12;
      chk("rst_pwm", 32'(bus.pwm_out), 32'd0);
      chk("rst_ps", 32'(bus.period_start), 32'd0);
      check_duty();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_period(0);
      check_period(0);

      // Single increase on channel 0
      do_press(0, 0);
      check_duty();
      wait_ps();
      check_period(0);

      // Saturation high then low
      repeat (7) do_press(0, 0);
      check_duty();
      wait_ps();
      check_period(0);
      repeat (12) do_press(0, 1);
      check_duty();
      wait_ps();
      check_period(0);

      // Glitch rejection and simultaneous inc/dec on channel 1
      do_press(1, 3);
      do_press(1, 2);
      check_duty();

      // Center-aligned with duty 5 on channel 0, then back to edge-aligned
      repeat (5) do_press(0, 0);
      check_duty();
      wait_ps();
      bus.center_mode = 1'b1;
      check_period(0);
      bus.center_mode = 1'b0;
      check_period(1);
      check_period(0);

      // Random presses
      for (int n = 0; n < 12; n++) begin
         do_press(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 3)));
         check_duty();
      end
      wait_ps();
      check_period(0);

      // Mid-operation reset with channel 0 at duty 8 and its output high
      while (duty_m[0] < 8) do_press(0, 0);
      while (duty_m[0] > 8) do_press(0, 1);
      wait_ps();
      @(negedge clk);
      chk("pre_rst_pwm0", 32'(bus.pwm_out[0]), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      duty_m[0] = 5;
      duty_m[1] = 5;
      #1;
      chk("midrst_pwm", 32'(bus.pwm_out), 32'd0);
      chk("midrst_ps", 32'(bus.period_start), 32'd0);
      check_duty();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_period(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
